// File: rtl/alu_pkg.sv
// Shared constants and types for the sequential divider.
package alu_pkg;

    // Default operand/result width in bits.
    localparam int DIV_WIDTH = 32;

    // Divider control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] partial,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Trial subtraction in WIDTH+1 bits; bit WIDTH set means it went negative.
    always_comb begin
        shifted = {partial, next_bit};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            q_bit    = 1'b1;
        end else begin
            rem_next = shifted[WIDTH-1:0];
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider32.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// MSB first, WIDTH iterations per operation, divide-by-zero short-cut.
module seq_divider32
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dsr_reg;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             accept;
    logic             last_iter;

    // A start is honoured in IDLE and DONE; in RUN it is ignored.
    assign accept    = start && (state != ST_RUN);
    assign last_iter = (count == CNT_W'(WIDTH - 1));

    // The dividend register shifts left each step, so its MSB feeds the
    // next trial and the new quotient bit enters at the LSB.
    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .partial (rem_reg),
        .next_bit(dvd_reg[WIDTH-1]),
        .divisor (dsr_reg),
        .rem_next(step_rem),
        .q_bit   (step_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (divisor == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (accept) begin
                    state_next = (divisor == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand latch, iteration datapath, and result registers (written only
    // on the transition into DONE so they hold between operations).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            dvd_reg   <= '0;
            rem_reg   <= '0;
            dsr_reg   <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
        end else if (accept) begin
            count <= '0;
            if (divisor == '0) begin
                quotient  <= '1;
                remainder <= dividend;
                dz        <= 1'b1;
            end else begin
                dvd_reg <= dividend;
                dsr_reg <= divisor;
                rem_reg <= '0;
            end
        end else if (state == ST_RUN) begin
            rem_reg <= step_rem;
            dvd_reg <= {dvd_reg[WIDTH-2:0], step_q};
            count   <= count + CNT_W'(1);
            if (last_iter) begin
                quotient  <= {dvd_reg[WIDTH-2:0], step_q};
                remainder <= step_rem;
                dz        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: directed scenarios plus a random
// regression against a plain-arithmetic reference model.
module tb_seq_divider32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        dz;

    int total;
    int bad;

    seq_divider32 #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .dz       (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned division, with the divide-by-zero convention.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r,
                           output logic z, output int lat);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; z = 1'b1; lat = 1;
        end else begin
            q = a / b; r = a % b; z = 1'b0; lat = 33;
        end
    endtask

    // Issue one operation and wait (bounded) for done. Returns the number of
    // rising edges from the start edge to the first cycle with done high,
    // and how many sampled cycles had busy high. Operands are scrambled
    // right after the start edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int edges, output int busy_cycles);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        edges = 1; busy_cycles = 0;
        while (!done && edges < 100) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        total++;
        if ({busy, done, quotient, remainder, dz} !== 67'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b q=%h r=%h dz=%b, required all zero",
                     busy, done, quotient, remainder, dz);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int n, bc;
        run_op(32'd100, 32'd7, n, bc);
        total++;
        if (n !== 33) begin
            bad++; $display("FAIL basic_latency: edges=%0d required 33", n);
        end
        total++;
        if (bc !== 32) begin
            bad++; $display("FAIL basic_busy_cycles: got %0d required 32", bc);
        end
        total++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || dz !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: q=%0d r=%0d dz=%b busy=%b, required 14 2 0 0",
                     quotient, remainder, dz, busy);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
            bad++;
            $display("FAIL basic_hold: done=%b q=%0d r=%0d, required 0 14 2", done, quotient, remainder);
        end
    endtask

    task automatic test_extremes();
        int n, bc;
        run_op(32'hFFFF_FFFF, 32'd1, n, bc);
        total++;
        if (n !== 33 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd0 || dz !== 1'b0) begin
            bad++;
            $display("FAIL max_div_one: edges=%0d q=%h r=%h dz=%b, required 33 ffffffff 0 0",
                     n, quotient, remainder, dz);
        end
        run_op(32'd3, 32'd10, n, bc);
        total++;
        if (n !== 33 || quotient !== 32'd0 || remainder !== 32'd3 || dz !== 1'b0) begin
            bad++;
            $display("FAIL small_div_big: edges=%0d q=%0d r=%0d dz=%b, required 33 0 3 0",
                     n, quotient, remainder, dz);
        end
    endtask

    task automatic test_div_zero();
        int n, bc;
        run_op(32'd5, 32'd0, n, bc);
        total++;
        if (n !== 1 || bc !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL dz_timing: edges=%0d busy_cycles=%0d busy=%b, required 1 0 0", n, bc, busy);
        end
        total++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || dz !== 1'b1) begin
            bad++;
            $display("FAIL dz_result: q=%h r=%0d dz=%b, required ffffffff 5 1", quotient, remainder, dz);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || dz !== 1'b1) begin
            bad++; $display("FAIL dz_hold: done=%b dz=%b, required 0 1", done, dz);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        n = 1;
        while (!done && n < 100) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (n !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
            bad++;
            $display("FAIL b2b_first: edges=%0d q=%0d r=%0d, required 33 14 2", n, quotient, remainder);
        end
        dividend = 32'd50;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1 || quotient !== 32'd14) begin
            bad++;
            $display("FAIL b2b_accept: busy=%b q=%0d, required 1 14", busy, quotient);
        end
        n = 1;
        while (!done && n < 100) begin
            @(posedge clk); #1; n++;
        end
        start = 1'b0;
        total++;
        if (n !== 33 || quotient !== 32'd7 || remainder !== 32'd1 || dz !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: edges=%0d q=%0d r=%0d dz=%b, required 33 7 1 0",
                     n, quotient, remainder, dz);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL b2b_release: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        int n, bc, pulses;
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, quotient, remainder, dz} !== 67'd0) begin
            bad++;
            $display("FAIL reset_mid_run: busy=%b done=%b q=%h r=%h dz=%b, required all zero",
                     busy, done, quotient, remainder, dz);
        end
        pulses = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++; $display("FAIL reset_abort: activity cycles=%0d required 0", pulses);
        end
        run_op(32'd9, 32'd2, n, bc);
        total++;
        if (n !== 33 || quotient !== 32'd4 || remainder !== 32'd1 || dz !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_op: edges=%0d q=%0d r=%0d dz=%b, required 33 4 1 0",
                     n, quotient, remainder, dz);
        end
    endtask

    function automatic logic [31:0] pick_operand(input bit allow_zero);
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0: pick_operand = allow_zero ? 32'd0 : 32'd1;
            1: pick_operand = 32'd1;
            2: pick_operand = 32'hFFFF_FFFF;
            3: pick_operand = 32'($urandom_range(0, 255));
            4: pick_operand = $urandom >> $urandom_range(0, 31);
            default: pick_operand = $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] a, b, eq, er;
        logic        ez;
        int          el, n, bc;
        logic [63:0] recon;
        for (int i = 0; i < 1500; i++) begin
            a = pick_operand(1'b1);
            b = pick_operand(1'b1);
            ref_div(a, b, eq, er, ez, el);
            run_op(a, b, n, bc);
            total++;
            if (quotient !== eq || remainder !== er || dz !== ez || n !== el) begin
                bad++;
                $display("FAIL random_%0d: %h/%h got q=%h r=%h dz=%b edges=%0d, required q=%h r=%h dz=%b edges=%0d",
                         i, a, b, quotient, remainder, dz, n, eq, er, ez, el);
            end
            if (b != 32'd0) begin
                recon = 64'(quotient) * 64'(b) + 64'(remainder);
                total++;
                if (recon !== 64'(a) || remainder >= b) begin
                    bad++;
                    $display("FAIL identity_%0d: %h/%h q*d+r=%h r=%h, required %h with r<d",
                             i, a, b, recon, remainder, a);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
